icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, word-granular instruction cache between the instruction fetch unit and the byte-serialising memory unit.
- Presents the fetch side with the same request/ready/result protocol the memory unit offers (pc, inst_req → inst_ready, inst_res).
- Forwards misses to the memory unit's instruction port and fills one line per miss.
- Cuts repeated-fetch latency from ~5 memory cycles to 1.

Parameters:
- IDX_BITS, 8, log2 of line count (256 one-word lines).
- ADDR_BITS, 18, physical address bits used; tag = pc[ADDR_BITS-1 : IDX_BITS+2].

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global enable; block frozen when low
- pc  input  32  fetch address from instruction unit; pc[1:0] ignored
- inst_req  input  1  fetch request, level, held by requester until inst_ready
- inst_ready  output  1  one-cycle pulse: inst_res valid for the request
- inst_res  output  32  fetched instruction word
- clear  input  1  pipeline flush (mispredict); drops pending response
- flush_all  input  1  invalidate every line (fence.i)
- mem_req  output  1  miss request to memory unit, level
- mem_addr  output  32  word-aligned miss address {pc[31:2],2'b00}
- mem_ready  input  1  one-cycle pulse from memory unit: mem_inst valid
- mem_inst  input  32  fill data

Behaviour:
- Reset (rst_in==0, async): all valid bits 0; state IDLE; inst_ready=0, inst_res=0, mem_req=0, mem_addr=0; abandon=0. Tag/data arrays need no reset.
- rdy_in==0: no state, array, or output register changes. Inputs sampled that cycle are ignored, including mem_ready (the memory unit freezes on the same rdy_in).
- States: IDLE, MISS.
- New request: accepted only when state==IDLE, inst_req==1, inst_ready==0, clear==0. This gives one response per request; hit throughput is one per 2 cycles.
- Hit (valid[idx] && tag match): next cycle inst_ready=1, inst_res=data[idx]. Hit latency is 1 cycle.
- Miss: next cycle mem_req=1, mem_addr=aligned pc, state→MISS. The miss address is latched; pc changes after acceptance are ignored.
- MISS:
  - mem_req held high until mem_ready is sampled.
  - On mem_ready: write data[idx]=mem_inst, tag, valid=1. Next cycle mem_req=0, state→IDLE, inst_ready=1, inst_res=mem_inst, unless abandon==1, in which case inst_ready stays 0.
  - abandon clears on return to IDLE.
- clear in IDLE: any response due next cycle is suppressed; no new request is accepted that cycle.
- clear in MISS: abandon=1. The in-flight bus transaction cannot be cancelled, so the cache waits for mem_ready and still fills the line (the data is correct for its address).
- clear and mem_ready in the same cycle: line filled, no inst_ready.
- flush_all in IDLE: all valid=0 next cycle; a hit lookup in the same cycle is treated as a miss.
- flush_all in MISS: all valid=0, the outstanding fill is NOT written, abandon=1.
- flush_all together with clear: flush_all semantics apply; clear additionally suppresses the response.
- inst_ready is never high for two consecutive cycles.
- mem_req is never high in IDLE.
- Index = pc[IDX_BITS+1:2]. Addresses differing only above ADDR_BITS alias; this is acceptable because the memory map is 18-bit.

Decomposition:
- Shared constants header: ICACHE_IDX_BITS, ICACHE_ADDR_BITS, state encodings (ICACHE_IDLE=1'b0, ICACHE_MISS=1'b1).
- One natural sub-module: icache_array. It holds the tag/valid/data storage with one combinational read port and one write port, plus a synchronous valid-clear with async reset of the valid bits. The control FSM stays in icache_direct.

Test Plan:
- Cold miss: reset, pc=0x00000010, inst_req=1. Expect mem_req=1 with mem_addr=0x10 the next cycle. Drive mem_ready with mem_inst=0x00A00093. Expect inst_ready pulse with inst_res=0x00A00093 one cycle later and mem_req=0.
- Hit after fill: re-request pc=0x10. Expect inst_ready 1 cycle after acceptance with 0x00A00093 and mem_req staying 0.
- Conflict: fill pc=0x10, then request pc=0x410 (same index, IDX_BITS=8). Expect a miss with mem_addr=0x410. After fill, pc=0x10 misses again.
- Clear during miss: request pc=0x20 (miss), assert clear 1 cycle later, mem_ready 3 cycles later with 0x12345678. Expect no inst_ready. A subsequent pc=0x20 request hits and returns 0x12345678.
- flush_all during miss: as above but assert flush_all instead. Expect no inst_ready, and a subsequent pc=0x20 request misses (mem_req=1). A previously filled pc=0x10 also misses.
- rdy_in stall plus async reset: with a miss outstanding, drop rdy_in for 4 cycles. Expect mem_req/mem_addr held and no state change. Then pulse rst_in low mid-cycle. Expect inst_ready=0 and mem_req=0 immediately, and all lines invalid.

Source files
------------

// File: rtl/icache_direct_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
package icache_direct_pkg;

  localparam int ICACHE_IDX_BITS  = 8;
  localparam int ICACHE_ADDR_BITS = 18;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_MISS = 1'b1
  } icache_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational read, single write port, whole-array
// valid clear. Only the valid bits see reset.
module icache_array
  import icache_direct_pkg::*;
#(
  parameter int IDX_BITS = ICACHE_IDX_BITS,
  parameter int TAG_BITS = ICACHE_ADDR_BITS - ICACHE_IDX_BITS - 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr_all,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [31:0]         rd_data,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [31:0]         wr_data
);

  localparam int LINES = 1 << IDX_BITS;

  logic [LINES-1:0]    valid_reg;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  // Clear wins over a same-cycle fill so a flush never leaves a stale line.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg[gi] <= 1'b0;
        end else if (en) begin
          if (clr_all) begin
            valid_reg[gi] <= 1'b0;
          end else if (wr_en && (wr_idx == IDX_BITS'(gi))) begin
            valid_reg[gi] <= 1'b1;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (en && wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_reg[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped one-word-per-line instruction cache sitting between the fetch
// unit and the memory unit's instruction port.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int IDX_BITS  = ICACHE_IDX_BITS,
  parameter int ADDR_BITS = ICACHE_ADDR_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] pc,
  input  logic        inst_req,
  output logic        inst_ready,
  output logic [31:0] inst_res,
  input  logic        clear,
  input  logic        flush_all,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_inst
);

  localparam int TAG_BITS = ADDR_BITS - IDX_BITS - 2;

  icache_state_t state_reg, state_next;
  logic [31:0]   mem_addr_reg, mem_addr_next;
  logic [31:0]   inst_res_reg, inst_res_next;
  logic          inst_ready_reg, inst_ready_next;
  logic          mem_req_reg, mem_req_next;
  logic          abandon_reg, abandon_next;
  logic          drop_fill_reg, drop_fill_next;

  logic                line_valid;
  logic [TAG_BITS-1:0] line_tag;
  logic [31:0]         line_data;
  logic                hit;
  logic                deliver;
  logic                wr_en;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^pc[1:0];
  assign hit = line_valid && (line_tag == pc[ADDR_BITS-1:IDX_BITS+2]);

  icache_array #(
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_array (
    .clk      (clk_in),
    .rst_n    (rst_in),
    .en       (rdy_in),
    .clr_all  (flush_all),
    .rd_idx   (pc[IDX_BITS+1:2]),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en),
    .wr_idx   (mem_addr_reg[IDX_BITS+1:2]),
    .wr_tag   (mem_addr_reg[ADDR_BITS-1:IDX_BITS+2]),
    .wr_data  (mem_inst)
  );

  always_comb begin
    state_next      = state_reg;
    mem_addr_next   = mem_addr_reg;
    inst_res_next   = inst_res_reg;
    inst_ready_next = 1'b0;
    mem_req_next    = mem_req_reg;
    abandon_next    = abandon_reg;
    drop_fill_next  = drop_fill_reg;
    wr_en           = 1'b0;
    deliver         = 1'b0;
    case (state_reg)
      ICACHE_IDLE: begin
        // A flush in the lookup cycle forces the miss path so no stale hit escapes.
        if (inst_req && !inst_ready_reg && !clear) begin
          if (hit && !flush_all) begin
            inst_ready_next = 1'b1;
            inst_res_next   = line_data;
          end else begin
            mem_req_next  = 1'b1;
            mem_addr_next = word_align(pc);
            state_next    = ICACHE_MISS;
          end
        end
      end
      ICACHE_MISS: begin
        if (mem_ready) begin
          // Data returned after a clear is still good for its address; after a flush it is not kept.
          wr_en           = !(flush_all || drop_fill_reg);
          deliver         = !(abandon_reg || clear || flush_all);
          inst_ready_next = deliver;
          if (deliver) begin
            inst_res_next = mem_inst;
          end
          mem_req_next   = 1'b0;
          state_next     = ICACHE_IDLE;
          abandon_next   = 1'b0;
          drop_fill_next = 1'b0;
        end else begin
          if (clear || flush_all) begin
            abandon_next = 1'b1;
          end
          if (flush_all) begin
            drop_fill_next = 1'b1;
          end
        end
      end
      default: state_next = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg      <= ICACHE_IDLE;
      mem_addr_reg   <= '0;
      inst_res_reg   <= '0;
      inst_ready_reg <= 1'b0;
      mem_req_reg    <= 1'b0;
      abandon_reg    <= 1'b0;
      drop_fill_reg  <= 1'b0;
    end else if (rdy_in) begin
      state_reg      <= state_next;
      mem_addr_reg   <= mem_addr_next;
      inst_res_reg   <= inst_res_next;
      inst_ready_reg <= inst_ready_next;
      mem_req_reg    <= mem_req_next;
      abandon_reg    <= abandon_next;
      drop_fill_reg  <= drop_fill_next;
    end
  end

  assign inst_ready = inst_ready_reg;
  assign inst_res   = inst_res_reg;
  assign mem_req    = mem_req_reg;
  assign mem_addr   = mem_addr_reg;

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: table-driven fetch vectors plus hand-written
// sequences for clear, flush, stall and asynchronous reset.
module tb_icache_direct;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] pc;
  logic        inst_req;
  logic        inst_ready;
  logic [31:0] inst_res;
  logic        clear;
  logic        flush_all;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_inst;

  int n_checks = 0;
  int n_fail   = 0;

  icache_direct dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .pc         (pc),
    .inst_req   (inst_req),
    .inst_ready (inst_ready),
    .inst_res   (inst_res),
    .clear      (clear),
    .flush_all  (flush_all),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_inst   (mem_inst)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] pc;
    logic        miss;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete fetch; on a miss the memory answers two cycles after the request.
  task automatic do_fetch(input logic [31:0] a, input logic miss, input logic [31:0] data);
    pc       = a;
    inst_req = 1'b1;
    step();
    if (miss) begin
      chk("miss_req", {31'd0, mem_req}, 32'd1);
      chk("miss_addr", mem_addr, {a[31:2], 2'b00});
      chk("miss_no_ready", {31'd0, inst_ready}, 32'd0);
      step();
      chk("miss_req_held", {31'd0, mem_req}, 32'd1);
      mem_ready = 1'b1;
      mem_inst  = data;
      step();
      mem_ready = 1'b0;
      chk("fill_ready", {31'd0, inst_ready}, 32'd1);
      chk("fill_res", inst_res, data);
      chk("fill_req_low", {31'd0, mem_req}, 32'd0);
    end else begin
      chk("hit_ready", {31'd0, inst_ready}, 32'd1);
      chk("hit_res", inst_res, data);
      chk("hit_no_req", {31'd0, mem_req}, 32'd0);
    end
    inst_req = 1'b0;
    step();
    chk("ready_pulse", {31'd0, inst_ready}, 32'd0);
    $display("fetch pc=%h miss=%0d res=%h", a, miss, data);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0010, 1'b1, 32'h00A0_0093};  // cold miss
    vecs[1] = '{32'h0000_0010, 1'b0, 32'h00A0_0093};  // hit after fill
    vecs[2] = '{32'h0000_0410, 1'b1, 32'h1111_1111};  // conflict, same index
    vecs[3] = '{32'h0000_0010, 1'b1, 32'h00A0_0093};  // evicted, misses again
    vecs[4] = '{32'h0000_0414, 1'b1, 32'h2222_2222};
    vecs[5] = '{32'h0000_0414, 1'b0, 32'h2222_2222};
    vecs[6] = '{32'h0000_0010, 1'b0, 32'h00A0_0093};
    vecs[7] = '{32'h0004_0010, 1'b0, 32'h00A0_0093};  // aliases above address bits
    vecs[8] = '{32'h0000_0013, 1'b0, 32'h00A0_0093};  // low pc bits ignored

    rst_in    = 1'b0;
    rdy_in    = 1'b1;
    pc        = '0;
    inst_req  = 1'b0;
    clear     = 1'b0;
    flush_all = 1'b0;
    mem_ready = 1'b0;
    mem_inst  = '0;
    step();
    step();
    chk("rst_ready", {31'd0, inst_ready}, 32'd0);
    chk("rst_res", inst_res, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    rst_in = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      do_fetch(vecs[i].pc, vecs[i].miss, vecs[i].data);
    end

    // clear one cycle into a miss: no response, line still filled
    pc       = 32'h0000_0020;
    inst_req = 1'b1;
    step();
    chk("clr_miss_req", {31'd0, mem_req}, 32'd1);
    clear    = 1'b1;
    inst_req = 1'b0;
    step();
    clear = 1'b0;
    step();
    step();
    mem_ready = 1'b1;
    mem_inst  = 32'h1234_5678;
    step();
    mem_ready = 1'b0;
    chk("clr_no_ready", {31'd0, inst_ready}, 32'd0);
    chk("clr_req_low", {31'd0, mem_req}, 32'd0);
    step();
    chk("clr_no_ready2", {31'd0, inst_ready}, 32'd0);
    $display("clear during miss pc=20");
    do_fetch(32'h0000_0020, 1'b0, 32'h1234_5678);

    // flush_all during a miss: no response, fill discarded, everything invalid
    pc       = 32'h0000_0024;
    inst_req = 1'b1;
    step();
    chk("fl_miss_req", {31'd0, mem_req}, 32'd1);
    flush_all = 1'b1;
    inst_req  = 1'b0;
    step();
    flush_all = 1'b0;
    step();
    step();
    mem_ready = 1'b1;
    mem_inst  = 32'h5555_5555;
    step();
    mem_ready = 1'b0;
    chk("fl_no_ready", {31'd0, inst_ready}, 32'd0);
    chk("fl_req_low", {31'd0, mem_req}, 32'd0);
    step();
    $display("flush during miss pc=24");
    do_fetch(32'h0000_0024, 1'b1, 32'h6666_6666);
    do_fetch(32'h0000_0010, 1'b1, 32'h00A0_0093);
    do_fetch(32'h0000_0020, 1'b1, 32'h1234_5678);

    // clear in IDLE blocks acceptance of a request that would hit
    pc       = 32'h0000_0010;
    inst_req = 1'b1;
    clear    = 1'b1;
    step();
    chk("idle_clr_ready", {31'd0, inst_ready}, 32'd0);
    chk("idle_clr_req", {31'd0, mem_req}, 32'd0);
    clear    = 1'b0;
    inst_req = 1'b0;
    step();
    $display("clear in idle pc=10");
    do_fetch(32'h0000_0010, 1'b0, 32'h00A0_0093);

    // flush_all in IDLE turns a would-be hit into a miss
    pc        = 32'h0000_0010;
    inst_req  = 1'b1;
    flush_all = 1'b1;
    step();
    flush_all = 1'b0;
    chk("idle_fl_req", {31'd0, mem_req}, 32'd1);
    chk("idle_fl_addr", mem_addr, 32'h0000_0010);
    chk("idle_fl_ready", {31'd0, inst_ready}, 32'd0);
    step();
    mem_ready = 1'b1;
    mem_inst  = 32'h00A0_0093;
    step();
    mem_ready = 1'b0;
    chk("idle_fl_fill", {31'd0, inst_ready}, 32'd1);
    chk("idle_fl_res", inst_res, 32'h00A0_0093);
    inst_req = 1'b0;
    step();
    $display("flush in idle pc=10");
    do_fetch(32'h0000_0024, 1'b1, 32'h6666_6666);

    // rdy_in stall with a miss outstanding; mem_ready during the stall is ignored
    pc       = 32'h0000_0050;
    inst_req = 1'b1;
    step();
    chk("stall_req", {31'd0, mem_req}, 32'd1);
    rdy_in    = 1'b0;
    mem_ready = 1'b1;
    mem_inst  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_req_held", {31'd0, mem_req}, 32'd1);
      chk("stall_addr_held", mem_addr, 32'h0000_0050);
      chk("stall_no_ready", {31'd0, inst_ready}, 32'd0);
    end
    rdy_in    = 1'b1;
    mem_ready = 1'b0;
    step();
    chk("stall_still_miss", {31'd0, mem_req}, 32'd1);
    $display("rdy stall pc=50");

    // asynchronous reset mid-cycle
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_ready", {31'd0, inst_ready}, 32'd0);
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    inst_req = 1'b0;
    step();
    rst_in = 1'b1;
    step();
    $display("async reset");
    do_fetch(32'h0000_0010, 1'b1, 32'h00A0_0093);
    do_fetch(32'h0000_0414, 1'b1, 32'h2222_2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
